operand_register_file: RTL and testbench

- Register bank directly upstream of the ALU: eight 32-bit registers, four general-purpose (R1–R4) and four scratch (S1–S4).
- Two combinational read ports, OutA and OutB, drive the ALU A and B inputs.
- Every register that is enabled in a cycle applies the same 3-bit register function to its contents or to input I on the rising clock edge.
- ALUOut is written back through I by the surrounding datapath.

---
 rtl/operand_register_file_pkg.sv | 25 ++
 rtl/operand_register_file_register_cell.sv | 47 ++++
 rtl/operand_register_file.sv | 46 ++++
 tb/tb_operand_register_file.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_register_file_pkg.sv
// Shared definitions for the operand register file, ALU and control unit:
// register function codes, read-select codes and the default data width.
package operand_register_file_pkg;

  localparam int RF_WIDTH = 32;

  localparam logic [2:0] RF_FUN_DEC        = 3'b000;
  localparam logic [2:0] RF_FUN_INC        = 3'b001;
  localparam logic [2:0] RF_FUN_LOAD       = 3'b010;
  localparam logic [2:0] RF_FUN_CLEAR      = 3'b011;
  localparam logic [2:0] RF_FUN_LOAD_B0    = 3'b100;
  localparam logic [2:0] RF_FUN_LOAD_H0    = 3'b101;
  localparam logic [2:0] RF_FUN_SHIFT_IN_B = 3'b110;
  localparam logic [2:0] RF_FUN_SEXT_H0    = 3'b111;

  localparam logic [2:0] OUT_SEL_R1 = 3'b000;
  localparam logic [2:0] OUT_SEL_R2 = 3'b001;
  localparam logic [2:0] OUT_SEL_R3 = 3'b010;
  localparam logic [2:0] OUT_SEL_R4 = 3'b011;
  localparam logic [2:0] OUT_SEL_S1 = 3'b100;
  localparam logic [2:0] OUT_SEL_S2 = 3'b101;
  localparam logic [2:0] OUT_SEL_S3 = 3'b110;
  localparam logic [2:0] OUT_SEL_S4 = 3'b111;

endpackage

// File: rtl/operand_register_file_register_cell.sv
// Single register of the operand register file; applies one of eight
// register functions on the rising edge when enabled, async-cleared by Reset.
module register_cell
  import operand_register_file_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = Q;
    case (FunSel)
      RF_FUN_DEC:        q_next = Q - ONE;
      RF_FUN_INC:        q_next = Q + ONE;
      RF_FUN_LOAD:       q_next = I;
      RF_FUN_CLEAR:      q_next = '0;
      RF_FUN_LOAD_B0: begin
        q_next      = '0;
        q_next[7:0] = I[7:0];
      end
      // Upper half is kept; only the low halfword is replaced.
      RF_FUN_LOAD_H0:    q_next[15:0] = I[15:0];
      RF_FUN_SHIFT_IN_B: q_next = {Q[WIDTH-9:0], I[7:0]};
      RF_FUN_SEXT_H0:    q_next = {{(WIDTH-16){I[15]}}, I[15:0]};
      default:           q_next = Q;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Q <= '0;
    end else if (E) begin
      Q <= q_next;
    end
  end

endmodule

// File: rtl/operand_register_file.sv
// Operand register file: four general-purpose and four scratch registers
// sharing one function code, with two combinational read ports for the ALU.
module operand_register_file
  import operand_register_file_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int NUM_GP  = 4,
  parameter int NUM_SCR = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  localparam int NUM_REGS = NUM_GP + NUM_SCR;

  // Index order matches the read-select encoding: R1..R4 then S1..S4.
  logic [NUM_REGS-1:0] en;
  logic [WIDTH-1:0]    q [NUM_REGS];

  assign en = {ScrSel, RegSel};

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
    register_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .Clock  (Clock),
      .Reset  (Reset),
      .E      (en[k]),
      .FunSel (FunSel),
      .I      (I),
      .Q      (q[k])
    );
  end

  assign OutA = q[OutASel];
  assign OutB = q[OutBSel];

endmodule

// File: tb/tb_operand_register_file.sv
// Bench for operand_register_file: directed scenarios plus randomized traffic
// compared every cycle against an array-based model of the eight registers.
module tb_operand_register_file;
  import operand_register_file_pkg::*;

  logic        Clock;
  logic        Reset;
  logic [31:0] I;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [31:0] OutA;
  logic [31:0] OutB;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  logic [31:0] m [8];

  operand_register_file dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .I       (I),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .ScrSel  (ScrSel),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [31:0] rf_next(input logic [2:0] f, input logic [31:0] q,
                                          input logic [31:0] d);
    case (f)
      3'd0:    return q - 32'd1;
      3'd1:    return q + 32'd1;
      3'd2:    return d;
      3'd3:    return 32'd0;
      3'd4:    return d & 32'h0000_00FF;
      3'd5:    return (q & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
      3'd6:    return (q << 8) | (d & 32'h0000_00FF);
      default: return (d & 32'h0000_FFFF) | (d[15] ? 32'hFFFF_0000 : 32'h0);
    endcase
  endfunction

  // Reference model: registers as a plain array, cleared by Reset at once.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < 8; k++) m[k] = 32'd0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if ((k < 4) ? RegSel[k] : ScrSel[k-4]) m[k] = rf_next(FunSel, m[k], I);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      check("model_outa", OutA, m[OutASel]);
      check("model_outb", OutB, m[OutBSel]);
    end
  end

  task automatic apply(input logic [2:0] f, input logic [31:0] d,
                       input logic [3:0] rs, input logic [3:0] ss);
    FunSel = f;
    I      = d;
    RegSel = rs;
    ScrSel = ss;
    @(posedge Clock);
    #2;
    RegSel = 4'b0;
    ScrSel = 4'b0;
  endtask

  task automatic peek(input string name, input logic [2:0] sel, input logic [31:0] exp);
    OutASel = sel;
    OutBSel = sel;
    #1;
    check({name, "_a"}, OutA, exp);
    check({name, "_b"}, OutB, exp);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) m[k] = 32'd0;
    Reset   = 1'b1;
    I       = 32'd0;
    FunSel  = RF_FUN_DEC;
    RegSel  = 4'b0;
    ScrSel  = 4'b0;
    OutASel = OUT_SEL_R1;
    OutBSel = OUT_SEL_S4;
    repeat (2) @(posedge Clock);
    #2;
    Reset = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset_outa", OutA, 32'd0);
    check("reset_outb", OutB, 32'd0);

    // Load every register, then clear asynchronously between edges.
    for (int k = 0; k < 8; k++) begin
      if (k < 4) apply(RF_FUN_LOAD, 32'h1111_1111 * (k + 1), 4'(1 << k), 4'b0);
      else       apply(RF_FUN_LOAD, 32'h1111_1111 * (k + 1), 4'b0, 4'(1 << (k - 4)));
    end
    peek("load_r1", OUT_SEL_R1, 32'h1111_1111);
    peek("load_s4", OUT_SEL_S4, 32'h8888_8888);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check("async_clr_a", OutA, 32'd0);
    check("async_clr_b", OutB, 32'd0);
    FunSel = RF_FUN_LOAD;
    I      = 32'hFFFF_FFFF;
    RegSel = 4'hF;
    ScrSel = 4'hF;
    @(posedge Clock);
    #2;
    check("reset_override", OutA, 32'd0);
    Reset  = 1'b0;
    RegSel = 4'b0;
    ScrSel = 4'b0;
    for (int k = 0; k < 8; k++) peek("post_reset", 3'(k), 32'd0);

    // Load and read through both ports.
    @(posedge Clock);
    #2;
    apply(RF_FUN_LOAD, 32'hDEAD_BEEF, 4'b0010, 4'b0);
    peek("r2_load", OUT_SEL_R2, 32'hDEAD_BEEF);
    peek("r1_untouched", OUT_SEL_R1, 32'd0);
    peek("s1_untouched", OUT_SEL_S1, 32'd0);

    // Wrap-around.
    @(posedge Clock);
    #2;
    apply(RF_FUN_LOAD, 32'hFFFF_FFFF, 4'b0, 4'b0001);
    apply(RF_FUN_INC, 32'd0, 4'b0, 4'b0001);
    peek("inc_wrap", OUT_SEL_S1, 32'd0);
    apply(RF_FUN_DEC, 32'd0, 4'b1000, 4'b0);
    peek("dec_wrap", OUT_SEL_R4, 32'hFFFF_FFFF);

    // Partial and extending loads on R3.
    @(posedge Clock);
    #2;
    apply(RF_FUN_LOAD, 32'hAABB_CCDD, 4'b0100, 4'b0);
    apply(RF_FUN_LOAD_H0, 32'h0000_1234, 4'b0100, 4'b0);
    peek("load_h0", OUT_SEL_R3, 32'hAABB_1234);
    @(posedge Clock);
    #2;
    apply(RF_FUN_SHIFT_IN_B, 32'h0000_0077, 4'b0100, 4'b0);
    peek("shift_in_b", OUT_SEL_R3, 32'hBB12_3477);
    @(posedge Clock);
    #2;
    apply(RF_FUN_SEXT_H0, 32'h0000_8001, 4'b0100, 4'b0);
    peek("sext_h0", OUT_SEL_R3, 32'hFFFF_8001);
    @(posedge Clock);
    #2;
    apply(RF_FUN_LOAD_B0, 32'h1234_56FE, 4'b0100, 4'b0);
    peek("load_b0", OUT_SEL_R3, 32'h0000_00FE);

    // Multi-enable and hold.
    @(posedge Clock);
    #2;
    apply(RF_FUN_LOAD, 32'd5, 4'b0001, 4'b0);
    apply(RF_FUN_LOAD, 32'd9, 4'b0, 4'b0010);
    apply(RF_FUN_INC, 32'd0, 4'b0001, 4'b0010);
    peek("multi_r1", OUT_SEL_R1, 32'd6);
    peek("multi_s2", OUT_SEL_S2, 32'd10);
    peek("multi_r2", OUT_SEL_R2, 32'hDEAD_BEEF);
    @(posedge Clock);
    #2;
    apply(RF_FUN_LOAD, 32'h5555_AAAA, 4'b0, 4'b0);
    peek("hold_r1", OUT_SEL_R1, 32'd6);
    peek("hold_s2", OUT_SEL_S2, 32'd10);

    // Read during write.
    @(posedge Clock);
    #2;
    apply(RF_FUN_LOAD, 32'd3, 4'b0001, 4'b0);
    FunSel  = RF_FUN_LOAD;
    I       = 32'd7;
    RegSel  = 4'b0001;
    OutASel = OUT_SEL_R1;
    #1;
    check("rdw_before", OutA, 32'd3);
    @(posedge Clock);
    #1;
    check("rdw_after", OutA, 32'd7);
    RegSel = 4'b0;
    @(posedge Clock);
    #2;

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 400; c++) begin
      int r;
      r = int'($urandom_range(0, 39));
      Reset = 1'b0;
      if (r == 0) begin
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
      end else if (r == 1) begin
        Reset = 1'b1;
      end
      FunSel  = 3'($urandom_range(0, 7));
      I       = $urandom;
      RegSel  = 4'($urandom) & 4'($urandom);
      ScrSel  = 4'($urandom) & 4'($urandom);
      OutASel = 3'($urandom_range(0, 7));
      OutBSel = 3'($urandom_range(0, 7));
      @(posedge Clock);
      #2;
    end
    Reset  = 1'b0;
    RegSel = 4'b0;
    ScrSel = 4'b0;
    @(posedge Clock);
    @(negedge Clock);
    #1;
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
